// File: rtl/rv32i_pkg.sv
// Shared encodings for the rv32i core: opcodes, funct3/funct7 codes, ALU operations.
// Also holds the default LED address and the funct3-to-ALU-op helper.
package rv32i_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_W    = 3'b010;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluMul
   } alu_op_e;

   // alt selects SUB for funct3=000 and SRA for funct3=101
   function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? AluSub : AluAdd;
         F3_SLL:  return AluSll;
         F3_SLT:  return AluSlt;
         F3_SLTU: return AluSltu;
         F3_XOR:  return AluXor;
         F3_SR:   return alt ? AluSra : AluSrl;
         F3_OR:   return AluOr;
         default: return AluAnd;
      endcase
   endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational ALU with branch compare flags for the rv32i core.
// AluMul is only implemented when RV32_MUL_EN is defined.
module rv32i_alu
   import rv32i_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  alu_op_e     alu_op_i,
   output logic [31:0] result_o,
   output logic        eq_o,
   output logic        lt_o,
   output logic        ltu_o
);

   assign eq_o  = (a_i == b_i);
   assign lt_o  = ($signed(a_i) < $signed(b_i));
   assign ltu_o = (a_i < b_i);

   always_comb begin
      result_o = '0;
      case (alu_op_i)
         AluAdd:  result_o = a_i + b_i;
         AluSub:  result_o = a_i - b_i;
         AluSll:  result_o = a_i << b_i[4:0];
         AluSlt:  result_o = {31'd0, lt_o};
         AluSltu: result_o = {31'd0, ltu_o};
         AluXor:  result_o = a_i ^ b_i;
         AluSrl:  result_o = a_i >> b_i[4:0];
         AluSra:  result_o = $signed(a_i) >>> b_i[4:0];
         AluOr:   result_o = a_i | b_i;
         AluAnd:  result_o = a_i & b_i;
`ifdef RV32_MUL_EN
         AluMul:  result_o = a_i * b_i;
`endif
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_cpu_core.sv
// Single-cycle RV32I core: PC, register file and decoder; the ALU is a sub-module.
// Define RV32_MUL_EN to decode MUL; otherwise that encoding executes as a NOP.
module rv32i_cpu_core
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] LED_ADDR = LED_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic [7:0]  led,
   output logic [31:0] inst_mem_in,
   input  logic [31:0] inst_mem_out,
   input  logic [31:0] data_mem_out,
   output logic [31:0] data_mem_addr,
   output logic [31:0] data_mem_WrData,
   output logic        data_mem_memwrite,
   output logic        data_mem_memread
);

   logic [31:0] pc_q, pc_d, pc_next, pc_plus4;
   logic [7:0]  led_q, led_d;
   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];

   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, alu_b, alu_res, wb_data;
   alu_op_e     alu_op;
   logic        alu_eq, alu_lt, alu_ltu;
   logic        rd_we, mem_rd, mem_wr, br_take;

   assign opcode = inst_mem_out[6:0];
   assign rd     = inst_mem_out[11:7];
   assign funct3 = inst_mem_out[14:12];
   assign rs1    = inst_mem_out[19:15];
   assign rs2    = inst_mem_out[24:20];
   assign funct7 = inst_mem_out[31:25];

   assign imm_i = {{20{inst_mem_out[31]}}, inst_mem_out[31:20]};
   assign imm_s = {{20{inst_mem_out[31]}}, inst_mem_out[31:25], inst_mem_out[11:7]};
   assign imm_b = {{19{inst_mem_out[31]}}, inst_mem_out[31], inst_mem_out[7],
                   inst_mem_out[30:25], inst_mem_out[11:8], 1'b0};
   assign imm_u = {inst_mem_out[31:12], 12'd0};
   assign imm_j = {{11{inst_mem_out[31]}}, inst_mem_out[31], inst_mem_out[19:12],
                   inst_mem_out[20], inst_mem_out[30:21], 1'b0};

   assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
   assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
   assign pc_plus4 = pc_q + 32'd4;

   // ALU operand/op select; kept apart from writeback so the ALU sits between two blocks
   always_comb begin
      alu_b  = imm_i;
      alu_op = AluAdd;
      case (opcode)
         OPC_BRANCH: alu_b = rs2_val;
         OPC_STORE:  alu_b = imm_s;
         OPC_OPIMM:  alu_op = alu_op_from_f3(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
         OPC_OP: begin
            alu_b  = rs2_val;
            alu_op = (funct7 == F7_MULDIV) ? AluMul : alu_op_from_f3(funct3, funct7 == F7_ALT);
         end
         default: ;
      endcase
   end

   rv32i_alu u_alu (
      .a_i      (rs1_val),
      .b_i      (alu_b),
      .alu_op_i (alu_op),
      .result_o (alu_res),
      .eq_o     (alu_eq),
      .lt_o     (alu_lt),
      .ltu_o    (alu_ltu)
   );

   always_comb begin
      rd_we   = 1'b0;
      wb_data = alu_res;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      br_take = 1'b0;
      pc_next = pc_plus4;
      case (opcode)
         OPC_LUI: begin
            rd_we   = 1'b1;
            wb_data = imm_u;
         end
         OPC_AUIPC: begin
            rd_we   = 1'b1;
            wb_data = pc_q + imm_u;
         end
         OPC_JAL: begin
            rd_we   = 1'b1;
            wb_data = pc_plus4;
            pc_next = pc_q + imm_j;
         end
         OPC_JALR: if (funct3 == 3'b000) begin
            rd_we   = 1'b1;
            wb_data = pc_plus4;
            pc_next = alu_res & ~32'd1;
         end
         OPC_BRANCH: begin
            case (funct3)
               F3_BEQ:  br_take = alu_eq;
               F3_BNE:  br_take = !alu_eq;
               F3_BLT:  br_take = alu_lt;
               F3_BGE:  br_take = !alu_lt;
               F3_BLTU: br_take = alu_ltu;
               F3_BGEU: br_take = !alu_ltu;
               default: br_take = 1'b0;
            endcase
            if (br_take) pc_next = pc_q + imm_b;
         end
         // Byte/half accesses are not supported and fall through as NOPs
         OPC_LOAD: if (funct3 == F3_W) begin
            mem_rd  = 1'b1;
            rd_we   = 1'b1;
            wb_data = data_mem_out;
         end
         OPC_STORE: mem_wr = (funct3 == F3_W);
         OPC_OPIMM: begin
            if (funct3 == F3_SLL)     rd_we = (funct7 == F7_BASE);
            else if (funct3 == F3_SR) rd_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            else                      rd_we = 1'b1;
         end
         OPC_OP: begin
            if (funct7 == F7_BASE)     rd_we = 1'b1;
            else if (funct7 == F7_ALT) rd_we = (funct3 == F3_ADD) || (funct3 == F3_SR);
`ifdef RV32_MUL_EN
            else if (funct7 == F7_MULDIV) rd_we = (funct3 == F3_ADD);
`endif
         end
         default: ;
      endcase
   end

   // Targets are forced word aligned, which also covers the JALR bit-0 clear
   assign pc_d = pc_next & ~32'd3;

   always_comb begin
      led_d = led_q;
      if (mem_wr && (alu_res == LED_ADDR)) led_d = rs2_val[7:0];
   end

   always_comb begin
      rf_d = rf_q;
      if (rd_we && (rd != 5'd0)) rf_d[rd] = wb_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         led_q <= '0;
         rf_q  <= '{default: '0};
      end else begin
         pc_q  <= pc_d;
         led_q <= led_d;
         rf_q  <= rf_d;
      end
   end

   assign led               = led_q;
   assign inst_mem_in       = pc_q;
   assign data_mem_addr     = alu_res;
   assign data_mem_WrData   = rs2_val;
   assign data_mem_memwrite = mem_wr & ~reset;
   assign data_mem_memread  = mem_rd;

endmodule

// File: tb/tb_rv32i_cpu_core.sv
// Directed bench for rv32i_cpu_core: drives one instruction word per cycle and checks
// PC, memory strobes, address, store data and LED with immediate assertions.
module tb_rv32i_cpu_core;

   logic        clk;
   logic        reset;
   logic [7:0]  led;
   logic [31:0] inst_mem_in, inst_mem_out, data_mem_out;
   logic [31:0] data_mem_addr, data_mem_WrData;
   logic        data_mem_memwrite, data_mem_memread;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [31:0] exp_mul;

   rv32i_cpu_core #(
      .RESET_PC (32'h0000_0000),
      .LED_ADDR (32'h0000_2000)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .led               (led),
      .inst_mem_in       (inst_mem_in),
      .inst_mem_out      (inst_mem_out),
      .data_mem_out      (data_mem_out),
      .data_mem_addr     (data_mem_addr),
      .data_mem_WrData   (data_mem_WrData),
      .data_mem_memwrite (data_mem_memwrite),
      .data_mem_memread  (data_mem_memread)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction encoders
   function automatic logic [31:0] opi(input int f3, input int rd, input int rs1, input int imm);
      logic [11:0] m = imm[11:0];
      return {m, rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
   endfunction
   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return opi(0, rd, rs1, imm);
   endfunction
   function automatic logic [31:0] opr(input int f7, input int f3, input int rd, input int rs1,
                                       input int rs2);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction
   function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
      logic [11:0] m = imm[11:0];
      return {m[11:5], rs2[4:0], rs1[4:0], 3'b010, m[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
      logic [11:0] m = imm[11:0];
      return {m, rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
   endfunction
   function automatic logic [31:0] lui(input int rd, input int imm);
      logic [19:0] m = imm[19:0];
      return {m, rd[4:0], 7'b0110111};
   endfunction
   function automatic logic [31:0] jalr(input int rd, input int rs1, input int imm);
      logic [11:0] m = imm[11:0];
      return {m, rs1[4:0], 3'b000, rd[4:0], 7'b1100111};
   endfunction
   function automatic logic [31:0] jal(input int rd, input int imm);
      logic [20:0] j = imm[20:0];
      return {j[20], j[10:1], j[11], j[19:12], rd[4:0], 7'b1101111};
   endfunction
   function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int imm);
      logic [12:0] b = imm[12:0];
      return {b[12], b[10:5], rs2[4:0], rs1[4:0], f3[2:0], b[4:1], b[11], 7'b1100011};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present an instruction and check the fetch address it is being executed at
   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      inst_mem_out = ins;
      #1;
      chk("pc", inst_mem_in, pc);
   endtask

   task automatic store_chk(input string tag, input logic [31:0] addr, input logic [31:0] wd);
      chk({tag, "_we"}, 32'(data_mem_memwrite), 32'd1);
      chk({tag, "_addr"}, data_mem_addr, addr);
      chk({tag, "_wd"}, data_mem_WrData, wd);
   endtask

   initial begin
`ifdef RV32_MUL_EN
      exp_mul = 32'd42;
`else
      exp_mul = 32'd1;
`endif
      reset        = 1'b1;
      data_mem_out = 32'hDEAD_BEEF;
      inst_mem_out = sw(0, 0, 0);
      tick;
      chk("rst_pc", inst_mem_in, 32'h0);
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_we", 32'(data_mem_memwrite), 32'd0);
      tick;
      chk("rst_pc2", inst_mem_in, 32'h0);
      chk("rst_we2", 32'(data_mem_memwrite), 32'd0);
      reset = 1'b0;

      // Arithmetic and compares
      issue(addi(1, 0, 5), 32'h00);                  tick;
      issue(addi(2, 0, -3), 32'h04);                 tick;
      issue(opr(0, 0, 3, 1, 2), 32'h08);             tick;
      issue(opr(32, 0, 4, 1, 2), 32'h0C);            tick;
      issue(opr(0, 2, 5, 2, 1), 32'h10);             tick;
      issue(opr(0, 3, 6, 2, 1), 32'h14);             tick;
      issue(sw(3, 0, 0), 32'h18);  store_chk("add", 32'h0, 32'h2);            tick;
      issue(sw(4, 0, 4), 32'h1C);  store_chk("sub", 32'h4, 32'h8);            tick;
      issue(sw(5, 0, 8), 32'h20);  store_chk("slt", 32'h8, 32'h1);            tick;
      issue(sw(6, 0, 12), 32'h24); store_chk("sltu", 32'hC, 32'h0);           tick;
      issue(sw(2, 0, 20), 32'h28); store_chk("addi_neg", 32'h14, 32'hFFFF_FFFD); tick;

      // LED-mapped store, plain store, load
      issue(addi(1, 0, 32'h55), 32'h2C);             tick;
      issue(lui(2, 2), 32'h30);                      tick;
      issue(sw(1, 2, 0), 32'h34);
      store_chk("led_sw", 32'h2000, 32'h55);
      chk("led_pre", 32'(led), 32'h0);
      tick;
      chk("led_post", 32'(led), 32'h55);
      issue(sw(2, 0, 16), 32'h38); store_chk("sw16", 32'h10, 32'h2000);
      tick;
      chk("led_keep", 32'(led), 32'h55);
      issue(lw(6, 0, 16), 32'h3C);
      data_mem_out = 32'h55;
      #1;
      chk("lw_rd", 32'(data_mem_memread), 32'd1);
      chk("lw_we", 32'(data_mem_memwrite), 32'd0);
      chk("lw_addr", data_mem_addr, 32'h10);
      tick;
      data_mem_out = 32'hDEAD_BEEF;
      issue(sw(6, 0, 4), 32'h40);
      store_chk("lw_val", 32'h4, 32'h55);
      chk("sw_rd", 32'(data_mem_memread), 32'd0);
      tick;

      // Control flow
      issue(jalr(0, 0, 16), 32'h44);                 tick;
      issue(br(0, 0, 0, 8), 32'h10);                 tick;
      issue(br(1, 0, 0, 8), 32'h18);                 tick;
      issue(addi(7, 0, 9), 32'h1C);                  tick;
      issue(jal(1, -16), 32'h20);                    tick;
      issue(addi(0, 0, 7), 32'h10);                  tick;
      issue(opr(0, 0, 7, 0, 0), 32'h14);             tick;
      issue(sw(7, 0, 8), 32'h18);  store_chk("x0", 32'h8, 32'h0);             tick;
      issue(sw(1, 0, 4), 32'h1C);  store_chk("jal_link", 32'h4, 32'h24);      tick;
      issue(addi(8, 0, -3), 32'h20);                 tick;
      issue(addi(9, 0, 5), 32'h24);                  tick;
      issue(br(4, 8, 9, 8), 32'h28);                 tick;
      issue(br(6, 8, 9, 8), 32'h30);                 tick;
      issue(br(5, 9, 8, -8), 32'h34);                tick;
      issue(br(7, 9, 8, 8), 32'h2C);                 tick;
      issue(opi(5, 13, 8, 32'h401), 32'h30);         tick;
      issue(sw(13, 0, 0), 32'h34); store_chk("srai", 32'h0, 32'hFFFF_FFFE);   tick;
      issue(32'h0000_0073, 32'h38);
      chk("ecall_we", 32'(data_mem_memwrite), 32'd0);
      chk("ecall_rd", 32'(data_mem_memread), 32'd0);
      tick;
      issue(addi(10, 0, 6), 32'h3C);                 tick;
      issue(addi(11, 0, 7), 32'h40);                 tick;
      issue(addi(12, 0, 1), 32'h44);                 tick;
      issue(opr(1, 0, 12, 10, 11), 32'h48);          tick;
      issue(sw(12, 0, 0), 32'h4C); store_chk("mul", 32'h0, exp_mul);          tick;
      issue(jalr(14, 9, 32'h19), 32'h50);            tick;
      issue(sw(14, 0, 0), 32'h1C); store_chk("jalr_link", 32'h0, 32'h54);     tick;

      // Reset mid-run: strobe gated, LED and registers cleared
      reset = 1'b1;
      issue(sw(1, 2, 0), 32'h20);
      chk("rst_mid_we", 32'(data_mem_memwrite), 32'd0);
      chk("rst_mid_addr", data_mem_addr, 32'h2000);
      tick;
      chk("rst_mid_led", 32'(led), 32'h0);
      reset = 1'b0;
      issue(sw(1, 2, 0), 32'h00);
      store_chk("rf_clr", 32'h0, 32'h0);
      tick;
      chk("led_after", 32'(led), 32'h0);
      chk("pc_after", inst_mem_in, 32'h04);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
